// File: rtl/ca_code_nco.sv
// ----------------------------------------------------------------------------
// ca_code_nco
//
// Code-rate NCO and chip sequencer feeding the C/A code generator. A phase
// accumulator advances by the programmed rate word every clock while running;
// its carry-out is the chip event and its MSB rising edge is the half-chip
// event. The sequencer turns these into a chip-advance strobe (ca_rd), a
// mid-chip strobe (half_rd) and tracks chip index and 1 ms code epochs. Code
// phase can be slewed (delayed) by swallowing a programmed number of chip
// events.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-low reset
//   start     pulse: reinitialise phase/counters and run (emits ca_set)
//   stop      pulse: return to IDLE, holding phase, chip_idx and ms_cnt
//   rate_wr   load rate into the rate register
//   rate      phase increment per clk (chip rate = rate/2^PHASE_W * f_clk)
//   slew_wr   load slew request (ignored in IDLE)
//   slew      number of chip events to suppress
//   ca_set    one-cycle load strobe to the code generator
//   ca_rd     one-cycle chip-advance strobe to the code generator
//   half_rd   one-cycle mid-chip strobe (RUN only)
//   chip_idx  current chip index, 0..CHIPS-1
//   epoch     pulse coincident with the ca_rd that wraps chip_idx to 0
//   ms_cnt    epoch count since start, wrapping
//   slewing   high while in SLEW
//   running   high in RUN or SLEW
// ----------------------------------------------------------------------------
module ca_code_nco #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned CHIPS   = 1023,
    parameter int unsigned SLEW_W  = 11,
    parameter int unsigned MS_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               rate_wr,
    input  logic [PHASE_W-1:0] rate,
    input  logic               slew_wr,
    input  logic [SLEW_W-1:0]  slew,
    output logic               ca_set,
    output logic               ca_rd,
    output logic               half_rd,
    output logic [9:0]         chip_idx,
    output logic               epoch,
    output logic [MS_W-1:0]    ms_cnt,
    output logic               slewing,
    output logic               running
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SLEW = 2'd2
    } state_e;

    localparam logic [9:0] LAST_CHIP = 10'(CHIPS - 1);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] rate_q, rate_d;
    logic [SLEW_W-1:0]  slew_cnt_q, slew_cnt_d;
    logic [9:0]         chip_idx_q, chip_idx_d;
    logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
    logic               ca_set_q, ca_set_d;
    logic               ca_rd_q, ca_rd_d;
    logic               half_rd_q, half_rd_d;
    logic               epoch_q, epoch_d;
    logic               slewing_q, running_q;

    logic [PHASE_W:0]   acc;
    logic               carry;
    logic               half_evt;

    // One extra bit captures the carry; at most one carry per clock since
    // rate < 2^PHASE_W.
    assign acc      = {1'b0, phase_q} + {1'b0, rate_q};
    assign carry    = acc[PHASE_W];
    assign half_evt = ~phase_q[PHASE_W-1] & acc[PHASE_W-1];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d    = state_q;
        phase_d    = phase_q;
        rate_d     = rate_wr ? rate : rate_q;
        slew_cnt_d = slew_cnt_q;
        chip_idx_d = chip_idx_q;
        ms_cnt_d   = ms_cnt_q;
        ca_set_d   = 1'b0;
        ca_rd_d    = 1'b0;
        half_rd_d  = 1'b0;
        epoch_d    = 1'b0;

        if (start) begin
            state_d    = ST_RUN;
            phase_d    = '0;
            chip_idx_d = '0;
            ms_cnt_d   = '0;
            slew_cnt_d = '0;
            ca_set_d   = 1'b1;
        end else if (stop) begin
            state_d    = ST_IDLE;
            slew_cnt_d = '0;
        end else if (state_q != ST_IDLE) begin
            phase_d = acc[PHASE_W-1:0];

            if (state_q == ST_RUN) begin
                half_rd_d = half_evt;
                if (carry) begin
                    ca_rd_d = 1'b1;
                    if (chip_idx_q == LAST_CHIP) begin
                        chip_idx_d = '0;
                        epoch_d    = 1'b1;
                        ms_cnt_d   = ms_cnt_q + MS_W'(1);
                    end else begin
                        chip_idx_d = chip_idx_q + 10'd1;
                    end
                end
            end else if (carry) begin
                // SLEW: the chip event is swallowed, holding the code back.
                slew_cnt_d = slew_cnt_q - SLEW_W'(1);
                if (slew_cnt_q == SLEW_W'(1)) begin
                    state_d = ST_RUN;
                end
            end

            // A new request replaces the pending count after this cycle's
            // carry has been handled under the old state.
            if (slew_wr) begin
                slew_cnt_d = slew;
                if (slew != '0) begin
                    state_d = ST_SLEW;
                end else if (state_q == ST_SLEW) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values; reset here is synchronous to clk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            rate_q     <= '0;
            slew_cnt_q <= '0;
            chip_idx_q <= '0;
            ms_cnt_q   <= '0;
            ca_set_q   <= 1'b0;
            ca_rd_q    <= 1'b0;
            half_rd_q  <= 1'b0;
            epoch_q    <= 1'b0;
            slewing_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rate_q     <= rate_d;
            slew_cnt_q <= slew_cnt_d;
            chip_idx_q <= chip_idx_d;
            ms_cnt_q   <= ms_cnt_d;
            ca_set_q   <= ca_set_d;
            ca_rd_q    <= ca_rd_d;
            half_rd_q  <= half_rd_d;
            epoch_q    <= epoch_d;
            slewing_q  <= (state_d == ST_SLEW);
            running_q  <= (state_d != ST_IDLE);
        end
    end

    assign ca_set   = ca_set_q;
    assign ca_rd    = ca_rd_q;
    assign half_rd  = half_rd_q;
    assign chip_idx = chip_idx_q;
    assign epoch    = epoch_q;
    assign ms_cnt   = ms_cnt_q;
    assign slewing  = slewing_q;
    assign running  = running_q;

endmodule

// File: tb/tb_ca_code_nco.sv
// ----------------------------------------------------------------------------
// tb_ca_code_nco
//
// Directed bench for ca_code_nco. Inputs change 1 ns after a rising edge and
// are captured at the next edge; outputs are sampled at the same point, so
// after each step() the outputs reflect the edge just taken. cyc numbers the
// edges, with the start edge numbered 1.
// ----------------------------------------------------------------------------
module tb_ca_code_nco;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        rate_wr = 1'b0;
    logic [31:0] rate = '0;
    logic        slew_wr = 1'b0;
    logic [10:0] slew = '0;
    logic        ca_set, ca_rd, half_rd, epoch, slewing, running;
    logic [9:0]  chip_idx;
    logic [15:0] ms_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [31:0] R_HALF    = 32'h8000_0000;
    localparam logic [31:0] R_QUARTER = 32'h4000_0000;

    ca_code_nco #(
        .PHASE_W(32), .CHIPS(1023), .SLEW_W(11), .MS_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .rate_wr(rate_wr), .rate(rate), .slew_wr(slew_wr), .slew(slew),
        .ca_set(ca_set), .ca_rd(ca_rd), .half_rd(half_rd),
        .chip_idx(chip_idx), .epoch(epoch), .ms_cnt(ms_cnt),
        .slewing(slewing), .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Step up to edge n, tallying strobes seen on the way.
    task automatic run_count(input int n, output int rd, output int hf,
                             output int ep, output int both);
        rd = 0; hf = 0; ep = 0; both = 0;
        while (cyc < n) begin
            step();
            rd   += int'(ca_rd);
            hf   += int'(half_rd);
            ep   += int'(epoch);
            both += int'(ca_rd & ca_set);
        end
    endtask

    task automatic write_rate(input logic [31:0] r);
        rate_wr = 1'b1; rate = r;
        step();
        rate_wr = 1'b0;
    endtask

    task automatic do_start();
        cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int rd, hf, ep, both, n_slew, bad_hold;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_ca_set",  32'(ca_set),   32'd0);
        check("rst_ca_rd",   32'(ca_rd),    32'd0);
        check("rst_half_rd", 32'(half_rd),  32'd0);
        check("rst_epoch",   32'(epoch),    32'd0);
        check("rst_chip",    32'(chip_idx), 32'd0);
        check("rst_ms",      32'(ms_cnt),   32'd0);
        check("rst_slewing", 32'(slewing),  32'd0);
        check("rst_running", 32'(running),  32'd0);
        rst = 1'b1;

        // ---------------- rate 2^31: chip every 2 clk ----------------
        write_rate(R_HALF);
        check("idle_after_rate", 32'(running), 32'd0);
        do_start();
        check("t1_ca_set",  32'(ca_set),   32'd1);
        check("t1_no_rd",   32'(ca_rd),    32'd0);
        check("t1_running", 32'(running),  32'd1);
        step();
        check("t1_half",    32'(half_rd),  32'd1);
        check("t1_set_off", 32'(ca_set),   32'd0);
        step();
        check("t1_first_rd", 32'(ca_rd),   32'd1);
        check("t1_chip1",    32'(chip_idx), 32'd1);
        run_count(2046, rd, hf, ep, both);
        check("t1_rd_count", 32'(rd),       32'd1021);
        check("t1_no_early_epoch", 32'(ep), 32'd0);
        check("t1_chip1022", 32'(chip_idx), 32'd1022);
        step();
        check("t1_epoch",   32'(epoch),    32'd1);
        check("t1_wrap_rd", 32'(ca_rd),    32'd1);
        check("t1_wrap",    32'(chip_idx), 32'd0);
        check("t1_ms1",     32'(ms_cnt),   32'd1);
        run_count(4093, rd, hf, ep, both);
        check("t1_epoch2",  32'(epoch),    32'd1);
        check("t1_ep_cnt",  32'(ep),       32'd1);
        check("t1_ms2",     32'(ms_cnt),   32'd2);
        run_count(7139, rd, hf, ep, both);
        check("t1_no_set_rd_overlap", 32'(both), 32'd0);
        check("t1_chip500", 32'(chip_idx), 32'd500);
        check("t1_ms3",     32'(ms_cnt),   32'd3);

        // ---------------- restart mid-run ----------------
        start = 1'b1; step(); start = 1'b0;
        check("restart_set",  32'(ca_set),   32'd1);
        check("restart_chip", 32'(chip_idx), 32'd0);
        check("restart_ms",   32'(ms_cnt),   32'd0);
        check("restart_rd",   32'(ca_rd),    32'd0);

        // ---------------- reset mid-run ----------------
        run_to(cyc + 9);
        rst = 1'b0; step(); rst = 1'b1;
        check("mrst_running", 32'(running),  32'd0);
        check("mrst_chip",    32'(chip_idx), 32'd0);
        check("mrst_strobes", 32'({ca_set, ca_rd, half_rd, epoch}), 32'd0);
        write_rate(R_HALF);
        run_count(cyc + 20, rd, hf, ep, both);
        check("mrst_idle_strobes", 32'(rd + hf + ep + int'(ca_set)), 32'd0);

        // ---------------- stop at chip 700 ----------------
        do_start();
        run_to(1401);
        check("stop_pre_chip", 32'(chip_idx), 32'd700);
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_running", 32'(running),  32'd0);
        check("stop_chip",    32'(chip_idx), 32'd700);
        slew_wr = 1'b1; slew = 11'd5; step(); slew_wr = 1'b0;
        check("idle_slew_ignored", 32'(slewing), 32'd0);
        run_count(cyc + 20, rd, hf, ep, both);
        check("stop_strobes",   32'(rd + hf + ep), 32'd0);
        check("stop_chip_held", 32'(chip_idx), 32'd700);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("startstop_set",  32'(ca_set),   32'd1);
        check("startstop_run",  32'(running),  32'd1);
        check("startstop_chip", 32'(chip_idx), 32'd0);

        // ---------------- rate 2^30 with 5-chip slew ----------------
        write_rate(R_QUARTER);
        do_start();
        run_to(400);
        check("s5_pre_chip", 32'(chip_idx), 32'd99);
        slew_wr = 1'b1; slew = 11'd5; step(); slew_wr = 1'b0;
        check("s5_chip100", 32'(chip_idx), 32'd100);
        check("s5_slewing", 32'(slewing),  32'd1);
        n_slew = 0; bad_hold = 0;
        while (slewing && n_slew < 100) begin
            n_slew++;
            bad_hold += int'(chip_idx != 10'd100) + int'(ca_rd & (cyc > 401)) + int'(half_rd);
            step();
        end
        check("s5_slew_clks", 32'(n_slew),   32'd20);
        check("s5_end_cyc",   32'(cyc),      32'd421);
        check("s5_hold",      32'(bad_hold), 32'd0);
        check("s5_end_chip",  32'(chip_idx), 32'd100);
        run_to(425);
        check("s5_resume_rd",   32'(ca_rd),    32'd1);
        check("s5_resume_chip", 32'(chip_idx), 32'd101);
        run_count(4112, rd, hf, ep, both);
        check("s5_no_early_epoch", 32'(ep), 32'd0);
        step();
        check("s5_late_epoch", 32'(epoch),  32'd1);
        check("s5_ms1",        32'(ms_cnt), 32'd1);

        // ---------------- slew replacement and slew=0 ----------------
        do_start();
        slew_wr = 1'b1; slew = 11'd5; step(); slew_wr = 1'b0;
        check("sr_slewing", 32'(slewing), 32'd1);
        run_count(13, rd, hf, ep, both);
        slew_wr = 1'b1; slew = 11'd3; step(); slew_wr = 1'b0;
        run_count(24, rd, hf, ep, both);
        check("sr_still_slewing", 32'(slewing), 32'd1);
        step();
        check("sr_done",       32'(slewing),  32'd0);
        check("sr_chip_held",  32'(chip_idx), 32'd0);
        check("sr_done_no_rd", 32'(ca_rd),    32'd0);
        run_count(29, rd, hf, ep, both);
        check("sr_first_rd",   32'(ca_rd),    32'd1);
        check("sr_chip1",      32'(chip_idx), 32'd1);
        check("sr_half_after", 32'(hf),       32'd1);
        slew_wr = 1'b1; slew = 11'd4; step();
        check("z_enter", 32'(slewing), 32'd1);
        slew = 11'd0; step(); slew_wr = 1'b0;
        check("z_exit",  32'(slewing), 32'd0);
        check("z_run",   32'(running), 32'd1);
        run_to(33);
        check("z_rd",   32'(ca_rd),    32'd1);
        check("z_chip", 32'(chip_idx), 32'd2);

        // ---------------- rate 0 hold then resume ----------------
        write_rate(R_HALF);
        do_start();
        run_to(20);
        rate_wr = 1'b1; rate = 32'd0; step(); rate_wr = 1'b0;
        check("r0_last_chip", 32'(chip_idx), 32'd10);
        run_count(10021, rd, hf, ep, both);
        check("r0_no_strobes", 32'(rd + hf), 32'd0);
        check("r0_chip_held",  32'(chip_idx), 32'd10);
        rate_wr = 1'b1; rate = R_HALF; step(); rate_wr = 1'b0;
        check("r0_wr_edge_quiet", 32'({ca_rd, half_rd}), 32'd0);
        step();
        check("r0_half", 32'(half_rd), 32'd1);
        step();
        check("r0_rd",   32'(ca_rd),    32'd1);
        check("r0_chip", 32'(chip_idx), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
